// File: rtl/lsu_mem_stage.sv
// RV32I load/store/retire stage: one outstanding data-memory transaction with
// byte-lane steering, alignment checking, load extension and an ack timeout.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_instr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_invalidate,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd_addr,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam logic [4:0] OP_LB  = 5'd16;
    localparam logic [4:0] OP_LH  = 5'd17;
    localparam logic [4:0] OP_LW  = 5'd18;
    localparam logic [4:0] OP_LBU = 5'd19;
    localparam logic [4:0] OP_LHU = 5'd20;
    localparam logic [4:0] OP_SB  = 5'd21;
    localparam logic [4:0] OP_SH  = 5'd22;
    localparam logic [4:0] OP_SW  = 5'd23;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_RETIRE = 2'd2;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        kill_q, kill_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        accept;
    logic        in_mem, in_store, in_byte, in_half, in_mis;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        q_load;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign accept = i_valid & o_ready & ~i_invalidate;

    // Decode of the operation being offered this cycle.
    always_comb begin
        in_mem   = (i_instr >= OP_LB) && (i_instr <= OP_SW);
        in_store = (i_instr == OP_SB) || (i_instr == OP_SH) || (i_instr == OP_SW);
        in_byte  = (i_instr == OP_LB) || (i_instr == OP_LBU) || (i_instr == OP_SB);
        in_half  = (i_instr == OP_LH) || (i_instr == OP_LHU) || (i_instr == OP_SH);
        in_mis   = in_mem && (in_half ? i_addr[0] : (!in_byte && (i_addr[1:0] != 2'b00)));
        if (in_byte) begin
            in_be    = 4'b0001 << i_addr[1:0];
            in_wdata = {4{i_store_data[7:0]}};
        end else if (in_half) begin
            in_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{i_store_data[15:0]}};
        end else begin
            in_be    = 4'b1111;
            in_wdata = i_store_data;
        end
    end

    // Load result extraction from the word returned with the ack.
    always_comb begin
        q_load  = (op_q >= OP_LB) && (op_q <= OP_LHU);
        ld_byte = i_dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'd0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        off_d     = off_q;
        rd_d      = rd_q;
        wb_en_d   = wb_en_q;
        wb_data_d = wb_data_q;
        mis_d     = mis_q;
        berr_d    = berr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = i_instr;
                    off_d     = i_addr[1:0];
                    rd_d      = i_rd_addr;
                    kill_d    = 1'b0;
                    berr_d    = 1'b0;
                    mis_d     = in_mis;
                    wb_en_d   = 1'b0;
                    wb_data_d = 32'd0;
                    if (in_mem && !in_mis) begin
                        state_d = ST_BUSY;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = in_store;
                        addr_d  = {i_addr[31:2], 2'b00};
                        be_d    = in_be;
                        wdata_d = in_wdata;
                    end else begin
                        state_d = ST_RETIRE;
                        if (!in_mem) begin
                            wb_en_d   = (i_rd_addr != 5'd0);
                            wb_data_d = i_addr;
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (i_invalidate) begin
                    kill_d = 1'b1;
                end
                // Ack takes priority over a timeout landing in the same cycle.
                if (i_dmem_ack || (cnt_q == TO_LAST)) begin
                    state_d   = ST_RETIRE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = 32'd0;
                    be_d      = 4'd0;
                    wdata_d   = 32'd0;
                    berr_d    = !i_dmem_ack;
                    wb_en_d   = i_dmem_ack && q_load && (rd_q != 5'd0);
                    wb_data_d = (i_dmem_ack && q_load) ? ld_val : 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RETIRE: begin
                state_d   = ST_IDLE;
                kill_d    = 1'b0;
                wb_en_d   = 1'b0;
                wb_data_d = 32'd0;
                mis_d     = 1'b0;
                berr_d    = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            kill_q    <= 1'b0;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
            op_q      <= 5'd0;
            off_q     <= 2'd0;
            rd_q      <= 5'd0;
            wb_en_q   <= 1'b0;
            wb_data_q <= 32'd0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            op_q      <= op_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    // Retire fields read as zero whenever the pulse is suppressed or absent.
    assign o_ready      = (state_q == ST_IDLE) & i_rst_n;
    assign o_wb_valid   = (state_q == ST_RETIRE) & ~kill_q & ~i_invalidate & i_rst_n;
    assign o_wb_en      = o_wb_valid & wb_en_q;
    assign o_wb_rd_addr = o_wb_valid ? rd_q : 5'd0;
    assign o_wb_data    = o_wb_valid ? wb_data_q : 32'd0;
    assign o_misaligned = o_wb_valid & mis_q;
    assign o_bus_err    = o_wb_valid & berr_q;

    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store and retire stage directly downstream of the ALU in the RV32I core. It accepts one ALU result per handshake and runs LB/LH/LW/LBU/LHU/SB/SH/SW as a single outstanding data-memory transaction (req/ack) with byte-lane steering, alignment checking, sign/zero extension and an ack timeout. Non-memory results pass through to writeback. Output goes to the register-file writeback port.

## Interface
- TIMEOUT_CYCLES, 255: cycles in BUSY without i_dmem_ack before a bus error; 1..255.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  ALU result valid.
- o_ready  out  1  stage can accept; equals (state==IDLE) & i_rst_n.
- i_instr  in  5  operator_e code of the instruction.
- i_addr  in  32  ALU result; effective address for memory ops, rd value otherwise.
- i_store_data  in  32  rs2 value for stores.
- i_rd_addr  in  5  destination register.
- i_invalidate  in  1  flush; kills the instruction offered this cycle and suppresses any pending writeback.
- o_dmem_req  out  1  memory request, held until ack.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  32  {addr[31:2],2'b00}.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_ack  in  1  request complete; rdata valid same cycle for loads.
- i_dmem_rdata  in  32  load word.
- o_wb_valid  out  1  one-cycle retire pulse.
- o_wb_en  out  1  write o_wb_data to o_wb_rd_addr.
- o_wb_rd_addr  out  5  destination register.
- o_wb_data  out  32  writeback value.
- o_misaligned  out  1  retire carries address-misaligned exception.
- o_bus_err  out  1  retire carries timeout exception.

## Operation
- Accept = i_valid & o_ready & ~i_invalidate; otherwise the input is ignored.
- FSM: IDLE, BUSY, RETIRE. IDLE→BUSY on an accepted aligned memory op. IDLE→RETIRE on any other accepted op. BUSY→RETIRE on ack or timeout. RETIRE→IDLE always.
- Non-memory op: o_wb_data=i_addr; o_wb_en=(rd!=0).
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. No request issued; retire with o_misaligned=1, o_wb_en=0, o_wb_data=0.
- Byte enables:
  - SB/LB/LBU: be = 4'b0001<<addr[1:0]; wdata = {4{data[7:0]}}.
  - SH/LH/LHU: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW/LW: be = 4'b1111; wdata = data.
- Load data, latched at ack:
  - LB: byte rdata[8*addr[1:0]+:8], sign-extended. LBU: same byte, zero-extended.
  - LH: half rdata[16*addr[1]+:16], sign-extended. LHU: same half, zero-extended.
  - LW: full word.
  - o_wb_en = (rd!=0).
- Stores retire with o_wb_en=0, o_wb_data=0.
- Timeout: 8-bit counter cleared on entering BUSY, incremented each BUSY cycle without ack. At count==TIMEOUT_CYCLES-1 with no ack: drop req, retire with o_bus_err=1, o_wb_en=0. Ack and timeout in the same cycle: ack wins. Ack seen in IDLE/RETIRE is ignored.
- i_invalidate in BUSY: the request still completes (ack or timeout), because a request cannot be retracted and an issued store commits. A kill flag is set, and the retire for that request has o_wb_valid=0.
- i_invalidate in RETIRE: o_wb_valid is forced 0 that cycle.

## Timing
- Reset (i_rst_n=0 at an edge): state=IDLE, kill=0, counter=0. All outputs 0, including o_ready while reset is low. Reset mid-BUSY drops o_dmem_req at that edge; the transaction is abandoned and no retire occurs.
- Non-memory or misaligned op accepted at edge N: o_wb_valid high in cycle N+1 only. o_ready low in N+1, high in N+2. Throughput is one op per 2 cycles.
- Memory op accepted at edge N:
  - o_dmem_req/we/addr/be/wdata registered and stable from cycle N+1 until the ack cycle M (M≥N+1) inclusive.
  - o_dmem_req low in M+1; o_wb_valid high in M+1 only; o_ready high in M+2.
- o_wb_* and exception flags are registered and valid only while o_wb_valid=1; they are 0 otherwise.

## Test plan
- ADD result 0x0000_1234, rd=5 → o_wb_valid one cycle later, o_wb_en=1, data 0x0000_1234, no dmem_req. Same with rd=0 → o_wb_en=0.
- LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles → be=1000, o_dmem_addr 0x100, wb data 0xFFFF_FF80. LBU gives 0x0000_0080. LHU addr 0x102 gives 0x0000_80FF.
- SH addr 0x0006, data 0xAAAA_BEEF → we=1, be=1100, wdata 0xBEEF_BEEF, req held until ack; retire o_wb_en=0.
- LW addr 0x0002 → no request; retire next cycle o_misaligned=1, o_wb_en=0. SH at 0x0001 behaves the same.
- LW with ack never asserted, TIMEOUT_CYCLES=4 → req high exactly 4 cycles then drops; retire o_bus_err=1. A late ack is ignored and o_ready returns high.
- Cover the flush and reset cases:
  - i_invalidate with i_valid in IDLE → nothing accepted.
  - i_invalidate during a BUSY load → ack consumed, no o_wb_valid.
  - Reset mid-BUSY → req 0 next edge, no retire.
